// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch port and
// the data port. Data wins ties, a starvation guard forces fetch service, and a
// timeout aborts memory accesses that never get m_ready.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  // fetch port
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  output logic              err,
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  // FSM state for observation
  output logic [1:0]        dbg_state_o
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [DATA_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic              d_done_q;
  logic              i_done_q;
  logic              err_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [SW-1:0]     starve_q;
  logic [TW-1:0]     tmo_q;

  logic grant_data_d;
  logic tmo_hit_d;

  // Data wins unless fetch is waiting and data has already had its fill.
  assign grant_data_d = d_req & (~i_req | (starve_q < SW'(STARVE_MAX)));
  assign tmo_hit_d    = (tmo_q == TW'(TIMEOUT - 1));

  // Memory handshake: m_req rises with m_addr/m_we/m_wdata and holds them
  // steady until the cycle m_ready is sampled high; that same cycle carries
  // m_rdata. m_ready outside an outstanding m_req is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      d_done_q  <= 1'b0;
      i_done_q  <= 1'b0;
      err_q     <= 1'b0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      starve_q  <= '0;
      tmo_q     <= '0;
    end else begin
      d_done_q <= 1'b0;
      i_done_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (grant_data_d) begin
            state_q   <= BUSY_D;
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            if (i_req) begin
              if (starve_q != SW'(STARVE_MAX)) starve_q <= starve_q + 1'b1;
            end else begin
              starve_q <= '0;
            end
          end else if (i_req) begin
            state_q   <= BUSY_I;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= i_addr;
            m_wdata_q <= '0;
            starve_q  <= '0;
          end else begin
            starve_q <= '0;
          end
        end
        BUSY_D, BUSY_I: begin
          if (m_ready) begin
            m_req_q <= 1'b0;
            state_q <= RESP;
            if (state_q == BUSY_D) begin
              d_done_q <= 1'b1;
              if (!m_we_q) d_rdata_q <= m_rdata;
            end else begin
              i_done_q  <= 1'b1;
              i_rdata_q <= m_rdata;
            end
          end else if (tmo_hit_d) begin
            // Abort: complete the access with err, read data left untouched.
            m_req_q <= 1'b0;
            state_q <= RESP;
            err_q   <= 1'b1;
            if (state_q == BUSY_D) d_done_q <= 1'b1;
            else                   i_done_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          tmo_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign d_done      = d_done_q;
  assign i_done      = i_done_q;
  assign err         = err_q;
  assign d_rdata     = d_rdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_stall     = d_req & ~d_done_q;
  assign i_stall     = i_req & ~i_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for single
// accesses, then hand-written starvation, timeout and reset sequences.
module tb_mem_port_arbiter;
  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] d_addr = '0, d_wdata = '0;
  logic         d_done, d_stall;
  logic [W-1:0] d_rdata;
  logic         i_req = 1'b0;
  logic [W-1:0] i_addr = '0;
  logic         i_done, i_stall;
  logic [W-1:0] i_rdata;
  logic         err;
  logic         m_req, m_we;
  logic [W-1:0] m_addr, m_wdata;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_rdata = '0;
  logic [1:0]   dbg_state;

  mem_port_arbiter #(.DATA_W(W), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .i_stall(i_stall), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .dbg_state_o(dbg_state)
  );

  int   passed = 0;
  int   total  = 0;
  logic auto_ready = 1'b0;
  logic both_done  = 1'b0;
  logic [W-1:0] exp_q[$];

  // scoreboard compare
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  // driver: one cycle, optional memory model answering the same cycle
  task automatic step();
    @(negedge clk);
    if (auto_ready) begin
      m_ready = m_req;
      m_rdata = m_addr ^ 32'hC0DE0000;
    end
    #1;
    if (d_done && i_done) both_done = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] d_req, d_we, d_addr, d_wdata, i_req, i_addr, m_ready, m_rdata;
    logic [W-1:0] e_m_req, e_m_we, e_m_addr, e_m_wdata;
    logic [W-1:0] e_d_done, e_i_done, e_err, e_d_stall, e_i_stall, e_d_rdata, e_i_rdata;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cnt, grants;
    logic seen, flag, prev;
    logic [W-1:0] e;

    //           d_req d_we d_addr        d_wdata         i_req i_addr  m_rdy m_rdata          | m_req m_we m_addr    m_wdata        dd id er ds is d_rdata         i_rdata
    vecs[0]  = '{1, 0, 32'h10, 0,             0, 0,      0, 0,               0, 0, 0,      0,             0, 0, 0, 1, 0, 0,              0};
    vecs[1]  = '{1, 0, 32'h10, 0,             0, 0,      0, 0,               1, 0, 32'h10, 0,             0, 0, 0, 1, 0, 0,              0};
    vecs[2]  = '{1, 0, 32'h10, 0,             0, 0,      0, 0,               1, 0, 32'h10, 0,             0, 0, 0, 1, 0, 0,              0};
    vecs[3]  = '{1, 0, 32'h10, 0,             0, 0,      1, 32'hDEADBEEF,    1, 0, 32'h10, 0,             0, 0, 0, 1, 0, 0,              0};
    vecs[4]  = '{1, 0, 32'h10, 0,             0, 0,      0, 0,               0, 0, 0,      0,             1, 0, 0, 0, 0, 32'hDEADBEEF,   0};
    vecs[5]  = '{0, 0, 0,      0,             0, 0,      0, 0,               0, 0, 0,      0,             0, 0, 0, 0, 0, 32'hDEADBEEF,   0};
    vecs[6]  = '{1, 0, 32'h20, 0,             1, 32'h100, 0, 0,              0, 0, 0,      0,             0, 0, 0, 1, 1, 32'hDEADBEEF,   0};
    vecs[7]  = '{1, 0, 32'h20, 0,             1, 32'h100, 1, 32'hA5A5A5A5,   1, 0, 32'h20, 0,             0, 0, 0, 1, 1, 32'hDEADBEEF,   0};
    vecs[8]  = '{1, 0, 32'h20, 0,             1, 32'h100, 0, 0,              0, 0, 0,      0,             1, 0, 0, 0, 1, 32'hA5A5A5A5,   0};
    vecs[9]  = '{0, 0, 0,      0,             1, 32'h100, 0, 0,              0, 0, 0,      0,             0, 0, 0, 0, 1, 32'hA5A5A5A5,   0};
    vecs[10] = '{0, 0, 0,      0,             1, 32'h100, 1, 32'h13,         1, 0, 32'h100, 0,            0, 0, 0, 0, 1, 32'hA5A5A5A5,   0};
    vecs[11] = '{0, 0, 0,      0,             1, 32'h100, 0, 0,              0, 0, 0,      0,             0, 1, 0, 0, 0, 32'hA5A5A5A5,   32'h13};
    vecs[12] = '{0, 0, 0,      0,             0, 0,      1, 32'hBAD,         0, 0, 0,      0,             0, 0, 0, 0, 0, 32'hA5A5A5A5,   32'h13};
    vecs[13] = '{1, 1, 32'h24, 32'h12345678,  0, 0,      0, 0,               0, 0, 0,      0,             0, 0, 0, 1, 0, 32'hA5A5A5A5,   32'h13};
    vecs[14] = '{1, 1, 32'h99, 0,             0, 0,      0, 0,               1, 1, 32'h24, 32'h12345678,  0, 0, 0, 1, 0, 32'hA5A5A5A5,   32'h13};
    vecs[15] = '{1, 1, 32'h99, 0,             0, 0,      1, 32'hFFFFFFFF,    1, 1, 32'h24, 32'h12345678,  0, 0, 0, 1, 0, 32'hA5A5A5A5,   32'h13};
    vecs[16] = '{0, 0, 0,      0,             0, 0,      0, 0,               0, 0, 0,      0,             1, 0, 0, 0, 0, 32'hA5A5A5A5,   32'h13};
    vecs[17] = '{0, 0, 0,      0,             0, 0,      0, 0,               0, 0, 0,      0,             0, 0, 0, 0, 0, 32'hA5A5A5A5,   32'h13};
    vecs[18] = '{0, 0, 0,      0,             1, 32'h104, 0, 0,              0, 0, 0,      0,             0, 0, 0, 0, 1, 32'hA5A5A5A5,   32'h13};
    vecs[19] = '{0, 0, 0,      0,             1, 32'h104, 1, 32'h33,         1, 0, 32'h104, 0,            0, 0, 0, 0, 1, 32'hA5A5A5A5,   32'h13};
    vecs[20] = '{0, 0, 0,      0,             0, 0,      0, 0,               0, 0, 0,      0,             0, 1, 0, 0, 0, 32'hA5A5A5A5,   32'h33};
    vecs[21] = '{0, 0, 0,      0,             0, 0,      0, 0,               0, 0, 0,      0,             0, 0, 0, 0, 0, 32'hA5A5A5A5,   32'h33};

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_m_we", m_we, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk1("rst_d_done", d_done, 1'b0);
    chk1("rst_i_done", i_done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'h0);

    // vector table: inputs for one cycle, outputs expected during that cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      d_req   = vecs[i].d_req[0];
      d_we    = vecs[i].d_we[0];
      d_addr  = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata;
      i_req   = vecs[i].i_req[0];
      i_addr  = vecs[i].i_addr;
      m_ready = vecs[i].m_ready[0];
      m_rdata = vecs[i].m_rdata;
      #1;
      chk1($sformatf("v%0d_m_req", i), m_req, vecs[i].e_m_req[0]);
      if (vecs[i].e_m_req[0]) begin
        chk1($sformatf("v%0d_m_we", i), m_we, vecs[i].e_m_we[0]);
        chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].e_m_addr);
        chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].e_m_wdata);
      end
      chk1($sformatf("v%0d_d_done", i), d_done, vecs[i].e_d_done[0]);
      chk1($sformatf("v%0d_i_done", i), i_done, vecs[i].e_i_done[0]);
      chk1($sformatf("v%0d_err", i), err, vecs[i].e_err[0]);
      chk1($sformatf("v%0d_d_stall", i), d_stall, vecs[i].e_d_stall[0]);
      chk1($sformatf("v%0d_i_stall", i), i_stall, vecs[i].e_i_stall[0]);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_d_rdata);
      chk($sformatf("v%0d_i_rdata", i), i_rdata, vecs[i].e_i_rdata);
    end

    // starvation: both requests held, memory answers immediately
    auto_ready = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; d_wdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h200;
    exp_q = '{32'h30, 32'h30, 32'h30, 32'h30, 32'h200, 32'h30, 32'h30};
    grants = 0;
    prev = 1'b0;
    for (int c = 0; c < 100 && grants < 7; c++) begin
      step();
      if (m_req && !prev) begin
        grants++;
        e = exp_q.pop_front();
        chk($sformatf("starve_grant%0d_addr", grants), m_addr, e);
        if (e == 32'h200) chk1("starve_fetch_we", m_we, 1'b0);
        if (grants == 7) begin
          d_req = 1'b0;
          i_req = 1'b0;
        end
      end
      prev = m_req;
    end
    chk("starve_grant_count", W'(grants), 32'd7);
    repeat (4) step();
    chk("starve_end_state", {30'b0, dbg_state}, 32'h0);
    chk("starve_d_rdata", d_rdata, 32'hC0DE0030);
    chk("starve_i_rdata", i_rdata, 32'hC0DE0200);
    chk1("never_both_done", both_done, 1'b0);

    // timeout: m_ready never comes
    auto_ready = 1'b0;
    m_ready = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    cnt = 0; seen = 1'b0; flag = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (d_done) begin
        seen = 1'b1;
        break;
      end
      if (m_req) cnt++;
      if (err) flag = 1'b1;
    end
    chk1("tmo_done_seen", seen, 1'b1);
    chk("tmo_m_req_cycles", W'(cnt), 32'd8);
    chk1("tmo_err", err, 1'b1);
    chk1("tmo_err_early", flag, 1'b0);
    chk1("tmo_m_req_low", m_req, 1'b0);
    chk("tmo_d_rdata", d_rdata, 32'hC0DE0030);
    d_req = 1'b0;
    step();
    m_ready = 1'b1;
    m_rdata = 32'h55555555;
    flag = 1'b0;
    step();
    m_ready = 1'b0;
    if (d_done || i_done) flag = 1'b1;
    repeat (3) begin
      step();
      if (d_done || i_done || m_req) flag = 1'b1;
    end
    chk1("stray_ready_ignored", flag, 1'b0);
    chk("stray_d_rdata", d_rdata, 32'hC0DE0030);
    chk("stray_state", {30'b0, dbg_state}, 32'h0);

    // reset in the middle of a fetch
    i_req = 1'b1; i_addr = 32'h300;
    step();
    chk1("rstmid_m_req_busy", m_req, 1'b1);
    chk("rstmid_state_busy_i", {30'b0, dbg_state}, 32'h2);
    rst = 1'b1;
    step();
    chk1("rstmid_m_req_dropped", m_req, 1'b0);
    chk("rstmid_state_idle", {30'b0, dbg_state}, 32'h0);
    rst = 1'b0;
    i_req = 1'b0;
    step();
    m_ready = 1'b1;
    m_rdata = 32'h77777777;
    flag = 1'b0;
    step();
    m_ready = 1'b0;
    if (i_done) flag = 1'b1;
    repeat (3) begin
      step();
      if (i_done || d_done || m_req) flag = 1'b1;
    end
    chk1("rstmid_no_done", flag, 1'b0);
    chk("rstmid_i_rdata", i_rdata, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
